// File: rtl/udp_multiport_parser.sv
// UDP header parser: matches dst port against NUM_PORTS programmable targets, forwards matching payload tagged with channel.
// Latency: payload byte registered 1 cycle after acceptance; header pulses 1 cycle after header byte 7. Backpressure: ready_out drops in PAYLOAD while output byte held and ready_in low.
// Optional: define UDP_LEN_CHECK_EN to enable len_error reporting (short length, truncated datagram).
module udp_multiport_parser #(
    parameter int NUM_PORTS = 4,
    parameter int CHAN_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [7:0]                data_in,
    input  logic                      data_valid_in,
    input  logic                      packet_start,
    input  logic                      ready_in,
    input  logic [16*NUM_PORTS-1:0]   target_ports,
    input  logic [NUM_PORTS-1:0]      port_enable,
    output logic                      ready_out,
    output logic [7:0]                payload_data_out,
    output logic                      payload_valid_out,
    output logic                      payload_last,
    output logic [CHAN_W-1:0]         payload_chan,
    output logic [15:0]               src_port,
    output logic [15:0]               dst_port,
    output logic [15:0]               length,
    output logic                      header_done,
    output logic                      match_hit,
    output logic                      drop_pulse,
    output logic                      len_error
);

    typedef enum logic [1:0] {ST_IDLE, ST_HEADER, ST_PAYLOAD, ST_DROP} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [2:0]          r_cnt;
    logic [7:0]          r_hdr [6];
    logic [15:0]         r_rem;
    logic [CHAN_W-1:0]   r_chan;
    logic                r_pvld;
    logic [7:0]          r_pdat;
    logic                r_plast;
    logic [CHAN_W-1:0]   r_pchan;
    logic [15:0]         r_src;
    logic [15:0]         r_dst;
    logic [15:0]         r_len;
    logic                r_hdr_done;
    logic                r_match;
    logic                r_drop;

    logic                w_acc;
    logic                w_start;
    logic                w_body;
    logic                w_hdr_last;
    logic [15:0]         w_dst;
    logic [15:0]         w_len;
    logic                w_no_pl;
    logic                w_hit;
    logic [CHAN_W-1:0]   w_idx;

    assign ready_out  = (r_state == ST_PAYLOAD) ? (!r_pvld || ready_in) : 1'b1;
    assign w_acc      = data_valid_in && ready_out;
    assign w_start    = w_acc && packet_start;
    assign w_body     = w_acc && !packet_start;
    assign w_hdr_last = w_body && (r_state == ST_HEADER) && (r_cnt == 3'd7);
    assign w_dst      = {r_hdr[2], r_hdr[3]};
    assign w_len      = {r_hdr[4], r_hdr[5]};
    assign w_no_pl    = (w_len <= 16'd8);

    // Descending scan so the lowest matching index wins.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (port_enable[i] && (target_ports[16*i +: 16] == w_dst)) begin
                w_hit = 1'b1;
                w_idx = CHAN_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_start) begin
            w_next = ST_HEADER;
        end else if (w_body) begin
            case (r_state)
                ST_HEADER: begin
                    if (r_cnt == 3'd7)
                        w_next = w_no_pl ? ST_IDLE : (w_hit ? ST_PAYLOAD : ST_DROP);
                end
                ST_PAYLOAD, ST_DROP: begin
                    if (r_rem == 16'd1) w_next = ST_IDLE;
                end
                default: w_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            for (int i = 0; i < 6; i++) r_hdr[i] <= '0;
            r_rem      <= '0;
            r_chan     <= '0;
            r_src      <= '0;
            r_dst      <= '0;
            r_len      <= '0;
            r_hdr_done <= 1'b0;
            r_match    <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_hdr_done <= 1'b0;
            r_match    <= 1'b0;
            r_drop     <= 1'b0;
            if (w_start) begin
                r_hdr[0] <= data_in;
                r_cnt    <= 3'd1;
            end else if (w_body && (r_state == ST_HEADER)) begin
                if (r_cnt < 3'd6) r_hdr[r_cnt] <= data_in;
                r_cnt <= r_cnt + 3'd1;
            end
            if (w_hdr_last) begin
                r_src      <= {r_hdr[0], r_hdr[1]};
                r_dst      <= w_dst;
                r_len      <= w_len;
                r_hdr_done <= 1'b1;
                r_rem      <= w_len - 16'd8;
                r_chan     <= w_idx;
                if (!w_no_pl) begin
                    r_match <= w_hit;
                    r_drop  <= !w_hit;
                end
            end else if (w_body && ((r_state == ST_PAYLOAD) || (r_state == ST_DROP))) begin
                r_rem <= r_rem - 16'd1;
            end
        end
    end

    // Output register: loads on accepted payload byte, otherwise drains when taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pvld  <= 1'b0;
            r_pdat  <= '0;
            r_plast <= 1'b0;
            r_pchan <= '0;
        end else if (w_body && (r_state == ST_PAYLOAD)) begin
            r_pvld  <= 1'b1;
            r_pdat  <= data_in;
            r_plast <= (r_rem == 16'd1);
            r_pchan <= r_chan;
        end else if (ready_in) begin
            r_pvld  <= 1'b0;
            r_plast <= 1'b0;
        end
    end

`ifdef UDP_LEN_CHECK_EN
    logic r_lerr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_lerr <= 1'b0;
        else        r_lerr <= (w_hdr_last && (w_len < 16'd8)) ||
                              (w_start && (r_state != ST_IDLE));
    end
    assign len_error = r_lerr;
`else
    assign len_error = 1'b0;
`endif

    assign payload_valid_out = r_pvld;
    assign payload_data_out  = r_pdat;
    assign payload_last      = r_plast;
    assign payload_chan      = r_pchan;
    assign src_port          = r_src;
    assign dst_port          = r_dst;
    assign length            = r_len;
    assign header_done       = r_hdr_done;
    assign match_hit         = r_match;
    assign drop_pulse        = r_drop;

endmodule

// File: doc/udp_multiport_parser.md
# udp_multiport_parser

Byte-stream UDP header parser that matches the destination port against `NUM_PORTS` run-time programmable target ports and forwards the payload of matching datagrams, tagged with the matched channel index. Non-matching datagrams are consumed and dropped. It is the multi-channel successor of the single-port UDP parser and sits between the IP-layer byte stream and the per-channel payload consumers.

## Interface
- `NUM_PORTS`, default 4: number of target-port comparators/channels (1..16).
- `CHAN_W`, default `$clog2(NUM_PORTS)` (minimum 1): width of channel tag.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `data_in` in 8: input byte.
- `data_valid_in` in 1: `data_in` valid.
- `packet_start` in 1: qualifies the accepted byte as UDP header byte 0.
- `ready_in` in 1: downstream can take a payload byte.
- `target_ports` in 16*NUM_PORTS: channel i port at bits [16i+15:16i].
- `port_enable` in NUM_PORTS: per-channel comparator enable.
- `ready_out` out 1: parser can accept a byte.
- `payload_data_out` out 8: payload byte.
- `payload_valid_out` out 1: payload byte valid.
- `payload_last` out 1: final payload byte of datagram.
- `payload_chan` out CHAN_W: matched channel for current payload.
- `src_port`, `dst_port`, `length` out 16 each: latched header fields.
- `header_done` out 1: one-cycle pulse, header fully parsed.
- `match_hit` out 1: one-cycle pulse with `header_done` when a channel matched.
- `drop_pulse` out 1: one-cycle pulse with `header_done` when no channel matched.
- `len_error` out 1: one-cycle pulse on length/truncation error (see Configuration).

## Operation
- Byte accepted when `data_valid_in && ready_out`.
- States: IDLE, HEADER, PAYLOAD, DROP.
- IDLE: accepted byte with `packet_start=1` → header byte 0, go HEADER; bytes without `packet_start` ignored (accepted, discarded).
- HEADER: bytes 0-7 big-endian: src(0-1), dst(2-3), length(4-5), checksum(6-7, discarded). 3-bit byte counter.
- On byte 7: latch fields, pulse `header_done`; select lowest index i with `port_enable[i] && target_ports[i]==dst_port`.
  - remaining = `length - 8` (16-bit). If `length <= 8`: go IDLE, no payload.
  - Else match → PAYLOAD with `payload_chan=i`, pulse `match_hit`; no match → DROP, pulse `drop_pulse`.
- PAYLOAD: each accepted byte loaded into the output register; remaining decrements; byte with remaining==1 flagged `payload_last`, then go IDLE.
- DROP: bytes consumed at full rate until remaining reaches 0, then go IDLE; no output.
- `packet_start=1` on an accepted byte in any state restarts at header byte 0 (current datagram abandoned; no `payload_last` emitted for it).
- `target_ports`/`port_enable` sampled only at header byte 7; changes mid-packet do not affect the current datagram.

## Timing
- Reset: state IDLE; all outputs 0 except `ready_out`=1 (no payload held).
- `ready_out`: 1 in IDLE/HEADER/DROP; in PAYLOAD = `!payload_valid_out || ready_in`.
- Payload latency: 1 cycle from accepted input byte to `payload_valid_out`.
- Output register holds data/`payload_last`/`payload_chan` stable while `payload_valid_out && !ready_in`; clears valid when taken and no new byte.
- `header_done`/`match_hit`/`drop_pulse` assert the cycle after header byte 7 is accepted; `dst_port`, `length` valid same cycle and held until next header byte 7.
- Back-to-back datagrams: header byte 0 of the next packet is accepted the cycle after `payload_last` byte is accepted (full throughput).
- Reset mid-operation: immediate return to reset values; pending output byte discarded.

## Configuration
- `UDP_LEN_CHECK_EN` defined: `len_error` pulses one cycle (a) with `header_done` when `length < 8`, (b) when `packet_start` restarts while in HEADER, PAYLOAD or DROP (truncated datagram). Case (a) returns to IDLE like zero payload.
- Undefined: `len_error` tied 0; `length < 8` treated as zero payload; restart silent.

## Test plan
- Ports {0x0035,0x1F90,0x0044,0x0043} all enabled, datagram dst=0x1F90 length=0x000C payload AA BB CC DD, `ready_in`=1 → 4 payload bytes, `payload_chan`=1, `payload_last` on DD, `match_hit` pulse, `header_done` once.
- Same stream, dst=0x9999 → no `payload_valid_out`, `drop_pulse`=1, next datagram parsed normally.
- Channels 0 and 2 both = 0x0050, only channel 2 enabled → `payload_chan`=2; both enabled → 0.
- `ready_in` toggled 1010… during a 6-byte payload → `ready_out` stalls input, all 6 bytes delivered in order, none duplicated, `payload_last` only on byte 6.
- With `UDP_LEN_CHECK_EN`: length=0x0004 → `len_error`+`header_done`, back to IDLE; `packet_start` at payload byte 2 → `len_error`, new header parsed.
- Assert `rst_n`=0 mid-payload with output stalled → all outputs 0, `ready_out`=1 next cycle, clean parse afterwards.
